// File: rtl/gain_offset_calibrator.sv
// rtl/gain_offset_calibrator.sv - two-phase offset/gain calibration with a sequential restoring divider
module gain_offset_calibrator #(
    parameter int W     = 24,
    parameter int FRAC  = 12,
    parameter int LOG2N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] din,
    input  logic                din_valid,
    input  logic signed [W-1:0] ref_target,
    input  logic                ref_ready,
    output logic                need_ref,
    output logic                busy,
    output logic signed [W-1:0] offset,
    output logic signed [W-1:0] gain,
    output logic                done,
    output logic                err,
    output logic                sat
);
    localparam int AW = W + LOG2N;
    localparam int QW = W + FRAC;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_WAIT,
        S_REF,
        S_DIV,
        S_DONE
    } state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [LOG2N-1:0]     cnt;
    logic signed [W-1:0]  zmean;
    logic signed [W-1:0]  rmean;
    logic [W:0]           span;
    logic [QW-1:0]        num;
    logic [W:0]           rem;
    logic [QW-1:0]        q;
    logic [CW-1:0]        div_cnt;
    logic                 div_run;

    logic signed [AW-1:0] din_ext;
    logic signed [AW-1:0] sum_c;
    logic signed [W-1:0]  mean_c;
    logic [W:0]           span_c;
    logic                 span_bad;
    logic                 tgt_bad;
    logic [QW-1:0]        num_c;
    logic [W+1:0]         rem_sh;
    logic [W+1:0]         diff;
    logic                 qbit;
    logic [W:0]           rem_nx;
    logic [QW-1:0]        q_nx;
    logic                 q_sat;
    logic signed [W-1:0]  gain_nx;

    always_comb begin
        din_ext  = {{LOG2N{din[W-1]}}, din};
        sum_c    = acc + din_ext;
        // Adding the bit just below the shift point equals adding 2^(LOG2N-1) before shifting.
        mean_c   = sum_c[AW-1:LOG2N] + {{(W-1){1'b0}}, sum_c[LOG2N-1]};
        span_c   = {rmean[W-1], rmean} - {zmean[W-1], zmean};
        span_bad = span_c[W] || (span_c == '0);
        tgt_bad  = ref_target[W-1] || (ref_target == '0);
        // Half the divisor is pre-added so the truncating divide rounds to nearest.
        num_c    = (QW'(ref_target) << FRAC) + QW'(span_c[W:1]);
        rem_sh   = {rem, num[QW-1]};
        diff     = rem_sh - {1'b0, span};
        qbit     = ~diff[W+1];
        rem_nx   = qbit ? diff[W:0] : rem_sh[W:0];
        q_nx     = {q[QW-2:0], qbit};
        q_sat    = |q_nx[QW-1:W-1];
        gain_nx  = q_sat ? {1'b0, {(W-1){1'b1}}} : q_nx[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            cnt      <= '0;
            zmean    <= '0;
            rmean    <= '0;
            span     <= '0;
            num      <= '0;
            rem      <= '0;
            q        <= '0;
            div_cnt  <= '0;
            div_run  <= 1'b0;
            need_ref <= 1'b0;
            busy     <= 1'b0;
            offset   <= '0;
            gain     <= W'(1) << FRAC;
            done     <= 1'b0;
            err      <= 1'b0;
            sat      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_ZERO;
                        busy  <= 1'b1;
                        acc   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                        sat   <= 1'b0;
                    end
                end
                S_ZERO: begin
                    if (din_valid) begin
                        acc <= sum_c;
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) begin
                            zmean    <= mean_c;
                            acc      <= '0;
                            cnt      <= '0;
                            need_ref <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (ref_ready) begin
                        need_ref <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= S_REF;
                    end
                end
                S_REF: begin
                    if (din_valid) begin
                        acc <= sum_c;
                        cnt <= cnt + 1'b1;
                        if (cnt == '1) begin
                            rmean   <= mean_c;
                            acc     <= '0;
                            cnt     <= '0;
                            div_run <= 1'b0;
                            state   <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (!div_run) begin
                        if (span_bad || tgt_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            span    <= span_c;
                            num     <= num_c;
                            rem     <= '0;
                            q       <= '0;
                            div_cnt <= CW'(QW - 1);
                            div_run <= 1'b1;
                        end
                    end else begin
                        rem     <= rem_nx;
                        q       <= q_nx;
                        num     <= num << 1;
                        div_cnt <= div_cnt - 1'b1;
                        if (div_cnt == '0) begin
                            // Offset and gain commit together so the correction path never sees a mix.
                            div_run <= 1'b0;
                            offset  <= zmean;
                            gain    <= gain_nx;
                            sat     <= q_sat;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gain_offset_calibrator.sv
// tb/tb_gain_offset_calibrator.sv - directed table-driven bench for gain_offset_calibrator
module tb_gain_offset_calibrator;
    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [23:0] din;
    logic               din_valid;
    logic signed [23:0] ref_target;
    logic               ref_ready;
    logic               need_ref;
    logic               busy;
    logic signed [23:0] offset;
    logic signed [23:0] gain;
    logic               done;
    logic               err;
    logic               sat;

    int checks = 0;
    int errors = 0;

    gain_offset_calibrator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .din_valid  (din_valid),
        .ref_target (ref_target),
        .ref_ready  (ref_ready),
        .need_ref   (need_ref),
        .busy       (busy),
        .offset     (offset),
        .gain       (gain),
        .done       (done),
        .err        (err),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [23:0] z;
        bit                 zalt;
        logic signed [23:0] r;
        logic signed [23:0] t;
        logic signed [23:0] eoff;
        logic [23:0]        egain;
        bit                 eerr;
        bit                 esat;
        bit                 stress;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic signed [23:0] v, input bit alt, input bit stress, input int nsamp);
        int n = 0;
        int guard = 0;
        while (n < nsamp && guard < 4000) begin
            din_valid = stress ? (guard % 2 == 0) : 1'b1;
            din       = (alt && n % 2 == 1) ? v + 24'sd1 : v;
            start     = (stress && guard % 37 == 5);
            @(negedge clk);
            if (din_valid) n++;
            guard++;
        end
        din_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic run_cal(input vec_t v, input int idx);
        bit seen = 0;
        ref_target = v.t;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("busy_after_start[%0d]", idx), 24'(busy), 24'd1);
        feed(v.z, v.zalt, v.stress, 256);
        chk($sformatf("need_ref[%0d]", idx), 24'(need_ref), 24'd1);
        if (v.stress) begin
            din_valid = 1'b1;
            din       = 24'sd12345;
            repeat (50) @(negedge clk);
            din_valid = 1'b0;
        end
        ref_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("need_ref_clear[%0d]", idx), 24'(need_ref), 24'd0);
        if (v.stress) ref_ready = 1'b0;
        feed(v.r, 1'b0, v.stress, 256);
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout[%0d]: got no done expected done within 100 cycles", idx);
        end else begin
            chk($sformatf("offset[%0d]", idx), offset, v.eoff);
            chk($sformatf("gain[%0d]", idx), gain, v.egain);
            chk($sformatf("err[%0d]", idx), 24'(err), 24'(v.eerr));
            chk($sformatf("sat[%0d]", idx), 24'(sat), 24'(v.esat));
            if (v.stress) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("done_pulse[%0d]", idx), 24'(done), 24'd0);
            chk($sformatf("busy_idle[%0d]", idx), 24'(busy), 24'd0);
        end
        ref_ready = 1'b0;
    endtask

    initial begin
        //          z    zalt r      t        eoff  egain      eerr esat stress
        vecs[0] = '{500, 0, 500,  4096,    0,   24'd4096,   1, 0, 0};
        vecs[1] = '{100, 0, 4196, 4096,    100, 24'd4096,   0, 0, 0};
        vecs[2] = '{-50, 0, 1998, 4096,    -50, 24'd8192,   0, 0, 0};
        vecs[3] = '{0,   0, 1,    4194304, 0,   24'h7FFFFF, 0, 1, 0};
        vecs[4] = '{0,   0, 100,  0,       0,   24'h7FFFFF, 1, 0, 0};
        vecs[5] = '{10,  0, 5,    4096,    0,   24'h7FFFFF, 1, 0, 0};
        vecs[6] = '{0,   0, 3,    1,       0,   24'd1365,   0, 0, 0};
        vecs[7] = '{0,   0, 3,    2,       0,   24'd2731,   0, 0, 0};
        vecs[8] = '{0,   1, 4097, 4096,    1,   24'd4096,   0, 0, 0};
        vecs[9] = '{100, 0, 4196, 4096,    100, 24'd4096,   0, 0, 1};

        rst        = 1'b1;
        start      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        ref_target = 24'sd4096;
        ref_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_offset", offset, 24'd0);
        chk("reset_gain", gain, 24'd4096);
        chk("reset_busy", 24'(busy), 24'd0);
        chk("reset_need_ref", 24'(need_ref), 24'd0);
        chk("reset_done", 24'(done), 24'd0);
        chk("reset_err", 24'(err), 24'd0);
        chk("reset_sat", 24'(sat), 24'd0);

        for (int i = 0; i < 10; i++) run_cal(vecs[i], i);

        // Reset in the middle of the reference phase, then a clean run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(24'sd7, 1'b0, 1'b0, 256);
        ref_ready = 1'b1;
        @(negedge clk);
        feed(24'sd900, 1'b0, 1'b0, 100);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        ref_ready = 1'b0;
        chk("midrst_busy", 24'(busy), 24'd0);
        chk("midrst_need_ref", 24'(need_ref), 24'd0);
        chk("midrst_offset", offset, 24'd0);
        chk("midrst_gain", gain, 24'd4096);
        chk("midrst_done", 24'(done), 24'd0);
        run_cal(vecs[1], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
